// File: rtl/ssd_pkg.sv
// Shared types and constants for the two-digit seven-segment scan controller.
package ssd_pkg;

  typedef enum logic [1:0] {
    SHOW_LO = 2'd0,
    GAP_LH  = 2'd1,
    SHOW_HI = 2'd2,
    GAP_HL  = 2'd3
  } state_e;

  // Segment patterns for hex 0..F, bit0=a ... bit6=g, active-high.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

endpackage

// File: rtl/ssd_scan_ctrl_hex7seg.sv
// Combinational hex-digit to seven-segment decoder.
module hex7seg
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = GLYPH[nibble];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Two-digit seven-segment scan scheduler with dead-time and frame-aligned value updates.
//
// state   | meaning
// SHOW_LO | low digit lit, SCAN_CYCLES long; entering it is the frame boundary
// GAP_LH  | segments blanked, select still low, DEAD_CYCLES long
// SHOW_HI | high digit lit, SCAN_CYCLES long
// GAP_HL  | segments blanked, select still high, DEAD_CYCLES long
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int SCAN_CYCLES = 6000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [7:0] value_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       blank_i,
  output logic [7:0] ssd_o
);

  localparam int MAX_LEN = (SCAN_CYCLES > DEAD_CYCLES) ? SCAN_CYCLES : DEAD_CYCLES;
  localparam int CW      = $clog2((MAX_LEN > 2) ? MAX_LEN : 2);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam bit NO_GAP = (DEAD_CYCLES == 0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q;
  logic [7:0]    disp_q, disp_d, shadow_q;
  logic          pending_q;
  logic          last, boundary;
  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic [7:0]    ssd_d;

  hex7seg u_dec (
    .nibble (nibble),
    .seg    (glyph)
  );

  assign ready_o = !pending_q;

  always_comb begin
    last     = (state_q == SHOW_LO || state_q == SHOW_HI) ? (cnt_q == SCAN_LAST)
                                                         : (cnt_q == DEAD_LAST);
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    // The first edge after reset only loads the display; counting starts from it.
    if (!run_q) begin
      state_d = SHOW_LO;
      cnt_d   = '0;
    end else if (last) begin
      cnt_d = '0;
      case (state_q)
        SHOW_LO: state_d = NO_GAP ? SHOW_HI : GAP_LH;
        GAP_LH:  state_d = SHOW_HI;
        SHOW_HI: state_d = NO_GAP ? SHOW_LO : GAP_HL;
        default: state_d = SHOW_LO;
      endcase
    end

    boundary = run_q && last && (state_d == SHOW_LO);
    disp_d   = (boundary && pending_q) ? shadow_q : disp_q;
    nibble   = (state_d == SHOW_HI) ? disp_d[7:4] : disp_d[3:0];

    case (state_d)
      SHOW_LO: ssd_d = {SEL_LO, blank_i ? 7'h00 : glyph};
      SHOW_HI: ssd_d = {SEL_HI, blank_i ? 7'h00 : glyph};
      GAP_LH:  ssd_d = {SEL_LO, 7'h00};
      default: ssd_d = {SEL_HI, 7'h00};
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= SHOW_LO;
      cnt_q     <= '0;
      run_q     <= 1'b0;
      disp_q    <= 8'h00;
      shadow_q  <= 8'h00;
      pending_q <= 1'b0;
      ssd_o     <= 8'h00;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ssd_o   <= ssd_d;
      // A new offer can only land while nothing is pending, so it never races the apply.
      if (valid_i && !pending_q) begin
        shadow_q  <= value_i;
        pending_q <= 1'b1;
      end else if (boundary && pending_q) begin
        pending_q <= 1'b0;
      end
    end
  end

endmodule
